// File: rtl/qpsk_zip_arbiter.sv
// Packet-atomic round-robin arbiter sharing one zip/decimate datapath between
// two QPSK AXI-Stream channels, with runaway-packet truncation and status counters.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no grant; arbitrate between pending sources (one cycle per packet)
// PASS  | granted source passed through combinationally to the zip datapath
// DROP  | packet hit the length limit; discard source beats until its tlast
module qpsk_zip_arbiter #(
  parameter int WIDTH       = 32,
  parameter int MAX_PKT_LEN = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s0_tdata,
  input  logic             s0_tlast,
  input  logic             s0_tvalid,
  output logic             s0_tready,
  input  logic [WIDTH-1:0] s1_tdata,
  input  logic             s1_tlast,
  input  logic             s1_tvalid,
  output logic             s1_tready,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tlast,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tuser,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1,
  output logic [CNT_W-1:0] trunc_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic [15:0]      LIMIT   = 16'(MAX_PKT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t      state, state_nxt;
  logic        sel, sel_nxt;
  logic        last_grant, last_grant_nxt;
  logic [15:0] beat_cnt, beat_cnt_nxt;
  logic        inc_pkt, inc_trunc;

  logic [WIDTH-1:0] sel_tdata;
  logic             sel_tlast;
  logic             sel_tvalid;
  logic             at_limit;

  assign sel_tdata  = sel ? s1_tdata  : s0_tdata;
  assign sel_tlast  = sel ? s1_tlast  : s0_tlast;
  assign sel_tvalid = sel ? s1_tvalid : s0_tvalid;
  assign at_limit   = (beat_cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      sel        <= 1'b0;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      last_grant <= last_grant_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    sel_nxt        = sel;
    last_grant_nxt = last_grant;
    beat_cnt_nxt   = beat_cnt;
    inc_pkt        = 1'b0;
    inc_trunc      = 1'b0;
    s0_tready      = 1'b0;
    s1_tready      = 1'b0;
    m_tdata        = '0;
    m_tlast        = 1'b0;
    m_tvalid       = 1'b0;
    m_tuser        = 1'b0;
    case (state)
      IDLE: begin
        if (s0_tvalid || s1_tvalid) begin
          sel_nxt        = (s0_tvalid && s1_tvalid) ? ~last_grant : s1_tvalid;
          last_grant_nxt = sel_nxt;
          beat_cnt_nxt   = '0;
          state_nxt      = PASS;
        end
      end
      PASS: begin
        m_tdata   = sel_tdata;
        m_tvalid  = sel_tvalid;
        m_tuser   = sel;
        m_tlast   = sel_tlast | at_limit;
        s0_tready = ~sel & m_tready;
        s1_tready = sel & m_tready;
        if (sel_tvalid && m_tready) begin
          beat_cnt_nxt = 16'(beat_cnt + 16'd1);
          // A natural tlast on the limit beat is not a truncation.
          if (sel_tlast) begin
            inc_pkt   = 1'b1;
            state_nxt = IDLE;
          end else if (at_limit) begin
            inc_pkt   = 1'b1;
            inc_trunc = 1'b1;
            state_nxt = DROP;
          end
        end
      end
      DROP: begin
        s0_tready = ~sel;
        s1_tready = sel;
        if (sel_tvalid && sel_tlast) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pkt_cnt0  <= '0;
      pkt_cnt1  <= '0;
      trunc_cnt <= '0;
    end else begin
      if (inc_pkt && !sel && pkt_cnt0 != CNT_MAX) pkt_cnt0 <= pkt_cnt0 + 1'b1;
      if (inc_pkt && sel && pkt_cnt1 != CNT_MAX)  pkt_cnt1 <= pkt_cnt1 + 1'b1;
      if (inc_trunc && trunc_cnt != CNT_MAX)      trunc_cnt <= trunc_cnt + 1'b1;
    end
  end

endmodule
